// File: rtl/ram_loader.sv
// Purpose : assembles big-endian 16-bit words from a byte stream and writes them to consecutive RAM16K addresses.
// Latency : one word needs at least 3 cycles (high byte, low byte, one write cycle); done pulses one cycle after the last write.
// Backpres: byte_ready is high only in RX_HI/RX_LO; a byte moves on a posedge with byte_valid & byte_ready, otherwise the state holds.
//
// Ports:
//   clock, reset (async active-low)     - clocking and reset
//   start, base_addr, length            - transfer request, sampled in IDLE only
//   byte_in, byte_valid, byte_ready     - valid/ready byte source
//   ram_in, ram_load, ram_address       - RAM16K write port (in/load/address)
//   busy, done                          - transfer status
//   checksum                            - running 16-bit sum of written words (only with CHECKSUM_EN)
// Optional feature macro: CHECKSUM_EN
module ram_loader #(
    parameter int ADDR_W = 14,
    parameter int LEN_W  = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [15:0]       ram_in,
    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_address,
    output logic              busy,
    output logic              done
`ifdef CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RX_HI = 3'd1,
        RX_LO = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;       // next address to write; ram_address holds its own copy
    logic [LEN_W-1:0]  remaining;  // words still to write, including the one in flight

    wire byte_xfer = byte_valid & byte_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            addr        <= '0;
            remaining   <= '0;
            byte_ready  <= 1'b0;
            ram_in      <= 16'h0000;
            ram_load    <= 1'b0;
            ram_address <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef CHECKSUM_EN
            checksum    <= 16'h0000;
`endif
        end else begin
            // Strobes default low; each is raised only on entry to its state.
            ram_load <= 1'b0;
            done     <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        addr      <= base_addr;
                        remaining <= length;
`ifdef CHECKSUM_EN
                        checksum  <= 16'h0000;
`endif
                        if (length == '0) begin
                            // Zero-length transfer skips straight to completion; busy never rises.
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= RX_HI;
                            busy       <= 1'b1;
                            byte_ready <= 1'b1;
                        end
                    end
                end

                RX_HI: begin
                    if (byte_xfer) begin
                        ram_in[15:8] <= byte_in;
                        state        <= RX_LO;
                    end
                end

                RX_LO: begin
                    if (byte_xfer) begin
                        ram_in[7:0] <= byte_in;
                        state       <= WRITE;
                        byte_ready  <= 1'b0;
                        ram_load    <= 1'b1;
                        ram_address <= addr;
                    end
                end

                WRITE: begin
                    // addr wraps naturally at 2**ADDR_W.
                    addr      <= addr + ADDR_W'(1);
                    remaining <= remaining - LEN_W'(1);
`ifdef CHECKSUM_EN
                    checksum  <= checksum + ram_in;
`endif
                    if (remaining == LEN_W'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state      <= RX_HI;
                        byte_ready <= 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state      <= IDLE;
                    byte_ready <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
module tb_ram_loader;

    localparam int ADDR_W = 14;
    localparam int LEN_W  = 15;

    logic              clock;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  length;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic [15:0]       ram_in;
    logic              ram_load;
    logic [ADDR_W-1:0] ram_address;
    logic              busy;
    logic              done;
`ifdef CHECKSUM_EN
    logic [15:0]       checksum;
`endif

    ram_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .length      (length),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .ram_in      (ram_in),
        .ram_load    (ram_load),
        .ram_address (ram_address),
        .busy        (busy),
        .done        (done)
`ifdef CHECKSUM_EN
        ,
        .checksum    (checksum)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    wr_t exp_q[$];
    int  load_cnt = 0;
    int  done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every write strobe is popped against the scoreboard.
    always @(negedge clock) begin
        if (reset && ram_load) begin
            wr_t e;
            load_cnt++;
            chk("ready_low_in_write", {31'd0, byte_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", {18'd0, ram_address}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", {18'd0, ram_address}, {18'd0, e.addr});
                chk("write_data", {16'd0, ram_in}, {16'd0, e.data});
            end
        end
        if (reset && done) done_cnt++;
    end

    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l);
        @(negedge clock);
        byte_valid = 1'b0;
        base_addr  = b;
        length     = l;
        start      = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Presents b; returns at the negedge where valid & ready are both high,
    // so the byte moves on the following posedge.
    task automatic send_byte(input logic [7:0] b, input bit rnd);
        for (int n = 0; n < 200; n++) begin
            @(negedge clock);
            if (rnd && $urandom_range(0, 1) == 0) begin
                byte_valid = 1'b0;
            end else begin
                byte_in    = b;
                byte_valid = 1'b1;
                if (byte_ready) return;
            end
        end
        chk("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic end_bytes();
        @(negedge clock);
        byte_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int n = 0; n < 100; n++) begin
            if (done) return;
            @(negedge clock);
        end
        chk(name, 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int l0, d0;
        reset      = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        length     = '0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        chk("rst_ram_load",   {31'd0, ram_load},   32'd0);
        chk("rst_busy",       {31'd0, busy},       32'd0);
        chk("rst_done",       {31'd0, done},       32'd0);
        chk("rst_ram_in",     {16'd0, ram_in},     32'd0);
        chk("rst_ram_addr",   {18'd0, ram_address}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // 1: basic two-word transfer, valid held high
        l0 = load_cnt; d0 = done_cnt;
        exp_q.push_back('{addr: 14'h0010, data: 16'hABCD});
        exp_q.push_back('{addr: 14'h0011, data: 16'h1234});
        do_start(14'h0010, 15'd2);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        send_byte(8'hAB, 0); send_byte(8'hCD, 0);
        send_byte(8'h12, 0); send_byte(8'h34, 0);
        end_bytes();
        wait_done("t1_done_timeout");
        chk("t1_busy_at_done", {31'd0, busy}, 32'd0);
        @(negedge clock);
        chk("t1_done_one_cycle", {31'd0, done}, 32'd0);
        chk("t1_loads", load_cnt - l0, 32'd2);
        chk("t1_dones", done_cnt - d0, 32'd1);
        chk("t1_addr_hold", {18'd0, ram_address}, 32'h0011);
        chk("t1_data_hold", {16'd0, ram_in}, 32'h1234);

        // 2: zero-length transfer
        l0 = load_cnt; d0 = done_cnt;
        do_start(14'h0123, 15'd0);
        chk("t2_done", {31'd0, done}, 32'd1);
        chk("t2_busy", {31'd0, busy}, 32'd0);
        chk("t2_ready", {31'd0, byte_ready}, 32'd0);
        repeat (4) @(negedge clock);
        chk("t2_ready_after", {31'd0, byte_ready}, 32'd0);
        chk("t2_loads", load_cnt - l0, 32'd0);
        chk("t2_dones", done_cnt - d0, 32'd1);

        // 3: address wrap at the top of memory
        l0 = load_cnt;
        exp_q.push_back('{addr: 14'h3FFF, data: 16'h0001});
        exp_q.push_back('{addr: 14'h0000, data: 16'h0002});
        do_start(14'h3FFF, 15'd2);
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'h00, 0); send_byte(8'h02, 0);
        end_bytes();
        wait_done("t3_done_timeout");
        @(negedge clock);
        chk("t3_loads", load_cnt - l0, 32'd2);

        // 4: random valid gaps plus an ignored start mid-transfer
        l0 = load_cnt; d0 = done_cnt;
        exp_q.push_back('{addr: 14'h0010, data: 16'hABCD});
        exp_q.push_back('{addr: 14'h0011, data: 16'h1234});
        do_start(14'h0010, 15'd2);
        send_byte(8'hAB, 1); send_byte(8'hCD, 1);
        do_start(14'h0200, 15'd5);
        chk("t4_busy_after_restart", {31'd0, busy}, 32'd1);
        send_byte(8'h12, 1); send_byte(8'h34, 1);
        end_bytes();
        wait_done("t4_done_timeout");
        @(negedge clock);
        repeat (6) @(negedge clock);
        chk("t4_loads", load_cnt - l0, 32'd2);
        chk("t4_dones", done_cnt - d0, 32'd1);
        chk("t4_idle_busy", {31'd0, busy}, 32'd0);

        // 5: reset after the high byte discards the partial word
        l0 = load_cnt;
        do_start(14'h0200, 15'd1);
        send_byte(8'h77, 0);
        @(negedge clock);
        reset      = 1'b0;
        byte_valid = 1'b0;
        #1;
        chk("t5_rst_ready", {31'd0, byte_ready}, 32'd0);
        chk("t5_rst_busy",  {31'd0, busy},       32'd0);
        chk("t5_rst_ram_in", {16'd0, ram_in},    32'd0);
        chk("t5_rst_addr",  {18'd0, ram_address}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("t5_no_write", load_cnt - l0, 32'd0);
        exp_q.push_back('{addr: 14'h0100, data: 16'h55AA});
        do_start(14'h0100, 15'd1);
        send_byte(8'h55, 0); send_byte(8'hAA, 0);
        end_bytes();
        wait_done("t5_done_timeout");
        @(negedge clock);
        chk("t5_loads", load_cnt - l0, 32'd1);

`ifdef CHECKSUM_EN
        // 6: checksum wraps modulo 2**16
        exp_q.push_back('{addr: 14'h0040, data: 16'hFFFF});
        exp_q.push_back('{addr: 14'h0041, data: 16'h0002});
        do_start(14'h0040, 15'd2);
        send_byte(8'hFF, 0); send_byte(8'hFF, 0);
        send_byte(8'h00, 0); send_byte(8'h02, 0);
        end_bytes();
        wait_done("t6_done_timeout");
        chk("t6_checksum", {16'd0, checksum}, 32'h0001);
        @(negedge clock);
`endif

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
